// File: rtl/matrix_cursor_demux_ctrl_pkg.sv
// Shared definitions for the cursor/demux controller: width helpers and
// the direction set with its fixed press priority.
package matrix_cursor_demux_ctrl_pkg;

  // Width needed to index n items, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Values double as bit positions in the press vector; up wins over down,
  // down over left, and left over right.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int NUM_DIRS = 4;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } move_t;

  function automatic move_t pick_move(input logic [NUM_DIRS-1:0] press);
    move_t m;
    m.valid = |press;
    if (press[DIR_UP])        m.dir = DIR_UP;
    else if (press[DIR_DOWN]) m.dir = DIR_DOWN;
    else if (press[DIR_LEFT]) m.dir = DIR_LEFT;
    else                      m.dir = DIR_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/matrix_cursor_demux_ctrl_btn_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for one raw
// push-button; emits a single-cycle press pulse per press.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       pulse_q;

  // The detector only arms after a real low level has crossed the
  // synchroniser, so a button held through reset release never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value
      // of its neighbour, which is what makes this a shift chain.
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~s2_q);
      pulse_q <= armed_q & s2_q & ~s3_q;
    end
  end

  assign press_o = pulse_q;

endmodule

// File: rtl/matrix_cursor_demux_ctrl.sv
// Button-driven cursor on a COLS x ROWS LED matrix with region demux select
// and a free-running row scan that lights the cursor column.
module matrix_cursor_demux_ctrl
  import matrix_cursor_demux_ctrl_pkg::*;
#(
  parameter  int COLS     = 8,
  parameter  int ROWS     = 8,
  parameter  int REG_C    = 4,
  parameter  int REG_R    = 2,
  parameter  int SCAN_DIV = 4,
  localparam int NOUT     = REG_R * REG_C,
  localparam int CW       = width_of(COLS),
  localparam int RW       = width_of(ROWS),
  localparam int SW       = width_of(NOUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            wrap_mode,
  input  logic            lock,
  output logic [CW-1:0]   mdc,
  output logic [RW-1:0]   mdl,
  output logic [SW-1:0]   dmx_sel,
  output logic [NOUT-1:0] dmx_out,
  output logic [ROWS-1:0] row_en,
  output logic [COLS-1:0] col_on,
  output logic            moved
);

  localparam int DW  = width_of(SCAN_DIV);
  localparam int RPR = ROWS / REG_R;
  localparam int CPR = COLS / REG_C;

  logic [NUM_DIRS-1:0] press;
  move_t               mv;

  btn_edge_sync u_sync_up    (.clk(clk), .rst(rst), .btn_i(btn_up),    .press_o(press[DIR_UP]));
  btn_edge_sync u_sync_down  (.clk(clk), .rst(rst), .btn_i(btn_down),  .press_o(press[DIR_DOWN]));
  btn_edge_sync u_sync_left  (.clk(clk), .rst(rst), .btn_i(btn_left),  .press_o(press[DIR_LEFT]));
  btn_edge_sync u_sync_right (.clk(clk), .rst(rst), .btn_i(btn_right), .press_o(press[DIR_RIGHT]));

  logic [CW-1:0]   mdc_q, mdc_d;
  logic [RW-1:0]   mdl_q, mdl_d;
  logic            moved_q, moved_d;
  logic [SW-1:0]   dmx_sel_q;
  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   scan_q, scan_d;
  logic [COLS-1:0] col_on_q, col_on_d;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    mdc_d = mdc_q;
    mdl_d = mdl_q;
    mv    = pick_move(press);
    if (mv.valid && !lock) begin
      case (mv.dir)
        DIR_UP:    if (mdl_q != '0)             mdl_d = mdl_q - RW'(1);
                   else if (wrap_mode)          mdl_d = RW'(ROWS - 1);
        DIR_DOWN:  if (mdl_q != RW'(ROWS - 1))  mdl_d = mdl_q + RW'(1);
                   else if (wrap_mode)          mdl_d = '0;
        DIR_LEFT:  if (mdc_q != '0)             mdc_d = mdc_q - CW'(1);
                   else if (wrap_mode)          mdc_d = CW'(COLS - 1);
        DIR_RIGHT: if (mdc_q != CW'(COLS - 1))  mdc_d = mdc_q + CW'(1);
                   else if (wrap_mode)          mdc_d = '0;
        default: ;
      endcase
    end
    moved_d = (mdc_d != mdc_q) || (mdl_d != mdl_q);

    div_d  = div_q + DW'(1);
    scan_d = scan_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d  = '0;
      scan_d = (scan_q == RW'(ROWS - 1)) ? '0 : scan_q + RW'(1);
    end

    // Built from next-state values so col_on lines up with row_en and the
    // cursor visible in the same cycle.
    col_on_d = '0;
    if (scan_d == mdl_d) col_on_d = {{(COLS-1){1'b0}}, 1'b1} << mdc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_q     <= '0;
      mdl_q     <= '0;
      moved_q   <= 1'b0;
      dmx_sel_q <= '0;
      div_q     <= '0;
      scan_q    <= '0;
      col_on_q  <= '0;
    end else begin
      mdc_q     <= mdc_d;
      mdl_q     <= mdl_d;
      moved_q   <= moved_d;
      dmx_sel_q <= SW'((int'(mdl_q) / RPR) * REG_C + int'(mdc_q) / CPR);
      div_q     <= div_d;
      scan_q    <= scan_d;
      col_on_q  <= col_on_d;
    end
  end

  assign mdc     = mdc_q;
  assign mdl     = mdl_q;
  assign moved   = moved_q;
  assign dmx_sel = dmx_sel_q;
  assign dmx_out = {{(NOUT-1){1'b0}}, 1'b1} << dmx_sel_q;
  assign row_en  = {{(ROWS-1){1'b0}}, 1'b1} << scan_q;
  assign col_on  = col_on_q;

endmodule

// File: tb/tb_matrix_cursor_demux_ctrl.sv
// Directed bench for matrix_cursor_demux_ctrl: a cycle-level behavioural model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_matrix_cursor_demux_ctrl;

  localparam int COLS     = 8;
  localparam int ROWS     = 8;
  localparam int REG_C    = 4;
  localparam int REG_R    = 2;
  localparam int SCAN_DIV = 4;
  localparam int NOUT     = REG_R * REG_C;

  // Button vector index: 0 up, 1 down, 2 left, 3 right.
  localparam logic [3:0] B_UP = 4'b0001, B_DN = 4'b0010, B_LF = 4'b0100, B_RT = 4'b1000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      btn = 4'b0;
  logic            wrap_mode = 1'b1;
  logic            lock = 1'b0;
  logic [2:0]      mdc;
  logic [2:0]      mdl;
  logic [2:0]      dmx_sel;
  logic [NOUT-1:0] dmx_out;
  logic [ROWS-1:0] row_en;
  logic [COLS-1:0] col_on;
  logic            moved;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  matrix_cursor_demux_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .REG_C(REG_C), .REG_R(REG_R), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .wrap_mode(wrap_mode), .lock(lock),
    .mdc(mdc), .mdl(mdl), .dmx_sel(dmx_sel), .dmx_out(dmx_out),
    .row_en(row_en), .col_on(col_on), .moved(moved)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A press acts on the edge three clocks after its raw rise is first
  // sampled, provided the low sample before that rise was taken after reset.
  int         m_cnt;
  logic [3:0] hist [4];   // hist[k] = raw levels sampled k+1 edges ago
  int         ex_col, ex_row, ex_sel, ex_scan;
  logic       ex_moved;
  logic [COLS-1:0] ex_colon;

  function automatic int region(input int c, input int r);
    return (r / (ROWS / REG_R)) * REG_C + c / (COLS / REG_C);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < 4; k++) hist[k] = 4'b0;
      ex_col = 0; ex_row = 0; ex_sel = 0; ex_scan = 0;
      ex_moved = 1'b0; ex_colon = '0;
    end else begin
      logic [3:0] rise;
      int nc, nr;
      m_cnt++;
      rise = (m_cnt >= 5) ? (hist[2] & ~hist[3]) : 4'b0;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn;
      ex_sel = region(ex_col, ex_row);
      nc = ex_col; nr = ex_row;
      if (!lock) begin
        if (rise[0])      nr = (ex_row > 0) ? ex_row - 1 : (wrap_mode ? ROWS - 1 : ex_row);
        else if (rise[1]) nr = (ex_row < ROWS - 1) ? ex_row + 1 : (wrap_mode ? 0 : ex_row);
        else if (rise[2]) nc = (ex_col > 0) ? ex_col - 1 : (wrap_mode ? COLS - 1 : ex_col);
        else if (rise[3]) nc = (ex_col < COLS - 1) ? ex_col + 1 : (wrap_mode ? 0 : ex_col);
      end
      ex_moved = (nc != ex_col) || (nr != ex_row);
      ex_col = nc; ex_row = nr;
      ex_scan = (m_cnt / SCAN_DIV) % ROWS;
      ex_colon = (ex_scan == ex_row) ? (COLS'(1) << ex_col) : '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_mdc",     64'(mdc),     64'(ex_col));
      check("model_mdl",     64'(mdl),     64'(ex_row));
      check("model_moved",   64'(moved),   64'(ex_moved));
      check("model_dmx_sel", 64'(dmx_sel), 64'(ex_sel));
      check("model_dmx_out", 64'(dmx_out), 64'(NOUT'(1) << ex_sel));
      check("model_row_en",  64'(row_en),  64'(ROWS'(1) << ex_scan));
      check("model_col_on",  64'(col_on),  64'(ex_colon));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] mask);
    @(negedge clk); #1 btn = btn | mask;
    repeat (2) @(negedge clk);
    #1 btn = btn & ~mask;
    repeat (6) @(negedge clk);
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    logic [ROWS-1:0] prev_row;
    bit seen;

    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mdc",     64'(mdc),     64'd0);
    check("rst_dmx_out", 64'(dmx_out), 64'd1);
    check("rst_row_en",  64'(row_en),  64'd1);
    check("rst_col_on",  64'(col_on),  64'd0);
    check("rst_moved",   64'(moved),   64'd0);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single right press: cursor moves on the third edge after sampling.
    #1 btn = B_RT;
    repeat (3) @(negedge clk);
    check("right_latency_before", 64'(mdc), 64'd0);
    @(negedge clk);
    check("right_mdc",   64'(mdc),   64'd1);
    check("right_moved", 64'(moved), 64'd1);
    @(negedge clk);
    check("right_moved_drop", 64'(moved),   64'd0);
    check("right_dmx_sel",    64'(dmx_sel), 64'd0);
    #1 btn = 4'b0;
    repeat (6) @(negedge clk);

    // Column edge with and without wrap.
    press_n(B_RT, 6);
    check("col7", 64'(mdc), 64'd7);
    press(B_RT);
    check("wrap_right_mdc", 64'(mdc), 64'd0);
    press(B_LF);
    check("wrap_left_mdc", 64'(mdc), 64'd7);
    #1 wrap_mode = 1'b0;
    press(B_RT);
    check("sat_right_mdc", 64'(mdc), 64'd7);
    press(B_UP);
    check("sat_up_mdl", 64'(mdl), 64'd0);

    // Simultaneous up+left from (2,3): only up takes effect.
    press_n(B_LF, 5);
    press_n(B_DN, 3);
    check("pos23_mdc", 64'(mdc), 64'd2);
    check("pos23_mdl", 64'(mdl), 64'd3);
    press(B_UP | B_LF);
    check("prio_mdc", 64'(mdc), 64'd2);
    check("prio_mdl", 64'(mdl), 64'd2);

    // Region mapping.
    press_n(B_RT, 4);
    press_n(B_DN, 3);
    check("reg65_dmx_sel", 64'(dmx_sel), 64'd7);
    check("reg65_dmx_out", 64'(dmx_out), 64'h80);
    press_n(B_LF, 5);
    press_n(B_UP, 5);
    check("reg10_mdc",     64'(mdc),     64'd1);
    check("reg10_dmx_sel", 64'(dmx_sel), 64'd0);

    // Lock discards presses; scan keeps stepping.
    #1 lock = 1'b1;
    press(B_RT); press(B_DN); press(B_LF);
    #1 lock = 1'b0;
    repeat (6) @(negedge clk);
    check("lock_mdc", 64'(mdc), 64'd1);
    check("lock_mdl", 64'(mdl), 64'd0);
    prev_row = row_en; seen = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV && !seen; i++) begin
      @(negedge clk);
      if (row_en != prev_row) seen = 1'b1;
    end
    check("scan_first_step_seen", 64'(seen), 64'd1);
    prev_row = row_en; gap = 0; seen = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (row_en != prev_row) seen = 1'b1;
    end
    check("scan_period", 64'(gap), 64'(SCAN_DIV));
    check("scan_rotate", 64'(row_en), 64'({prev_row[ROWS-2:0], prev_row[ROWS-1]}));

    // Down held across reset release produces no move.
    #1 wrap_mode = 1'b1;
    @(negedge clk); #1 rst = 1'b1; btn = B_DN;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    #1 btn = 4'b0;
    repeat (8) @(negedge clk);
    check("held_rst_mdl", 64'(mdl), 64'd0);
    check("held_rst_mdc", 64'(mdc), 64'd0);

    // Reset one cycle after a raw edge aborts the press.
    press(B_RT);
    check("pre_abort_mdc", 64'(mdc), 64'd1);
    @(negedge clk); #1 btn = B_DN;
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_rst_mdc",     64'(mdc),     64'd0);
    check("abort_rst_dmx_out", 64'(dmx_out), 64'd1);
    check("abort_rst_row_en",  64'(row_en),  64'd1);
    check("abort_rst_col_on",  64'(col_on),  64'd0);
    #1 rst = 1'b0; btn = 4'b0;
    repeat (8) @(negedge clk);
    check("abort_mdl",     64'(mdl),     64'd0);
    check("abort_dmx_sel", 64'(dmx_sel), 64'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
